// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: drives a shared single-cycle alu to run unsigned multiply
// by repeated ADD and unsigned divide by repeated SUBS.
// Ports:
//   clk, rst         rising-edge clock, async active-high reset
//   i_start/o_ready  command request, accepted only while o_ready=1
//   i_op             0=MUL, 1=DIV
//   i_a, i_b         operands, sampled on the accept edge
//   o_done           one-cycle pulse, results valid
//   o_result, o_rem  product/quotient and remainder (0 for MUL)
//   o_ovf, o_err     MUL overflow, divide by zero
//   o_alu_a/b/sltr   alu operands and operation select
//   i_alu_val        alu result
// Optional macro ALU_SEQ_MUL_SWAP_EN: MUL iterates min(a,b) times.

package pkg_system_mdr;
    typedef logic [7:0] data_t;
    typedef enum logic [1:0] {
        NULL = 2'd0,
        ADD  = 2'd1,
        SUBS = 2'd2
    } op_t;
endpackage

module alu_seq_ctrl
    import pkg_system_mdr::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic          o_ready,
    output logic          o_done,
    output logic [DW-1:0] o_result,
    output logic [DW-1:0] o_rem,
    output logic          o_ovf,
    output logic          o_err,
    output logic [DW-1:0] o_alu_a,
    output logic [DW-1:0] o_alu_b,
    output op_t           o_alu_sltr,
    input  logic [DW-1:0] i_alu_val
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] cnt_q, cnt_d;
    // Holds the addend for MUL and the divisor for DIV.
    logic [DW-1:0] opnd_q, opnd_d;
    logic [DW-1:0] limit_q, limit_d;
    logic          op_q, op_d;
    logic          done_q, done_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            limit_q  <= '0;
            op_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            limit_q  <= limit_d;
            op_q     <= op_d;
            done_q   <= done_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        limit_d    = limit_q;
        op_d       = op_q;
        done_d     = 1'b0;
        result_d   = result_q;
        rem_d      = rem_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        o_alu_sltr = NULL;
        o_alu_a    = acc_q;
        o_alu_b    = '0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    op_d  = i_op;
                    ovf_d = 1'b0;
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (!i_op) begin
                        acc_d   = '0;
`ifdef ALU_SEQ_MUL_SWAP_EN
                        // Fewer iterations when the smaller operand counts.
                        limit_d = (i_a < i_b) ? i_a : i_b;
                        opnd_d  = (i_a < i_b) ? i_b : i_a;
`else
                        limit_d = i_b;
                        opnd_d  = i_a;
`endif
                        state_d = RUN;
                    end else if (i_b != '0) begin
                        acc_d   = i_a;
                        opnd_d  = i_b;
                        state_d = RUN;
                    end else begin
                        err_d    = 1'b1;
                        result_d = '1;
                        rem_d    = i_a;
                        state_d  = DONE;
                    end
                end
            end
            RUN: begin
                if (!op_q) begin
                    if (cnt_q == limit_q) begin
                        result_d = acc_q;
                        rem_d    = '0;
                        state_d  = DONE;
                    end else begin
                        o_alu_sltr = ADD;
                        o_alu_b    = opnd_q;
                        acc_d      = i_alu_val;
                        cnt_d      = cnt_q + ONE;
                        // A smaller sum means the add wrapped.
                        if (i_alu_val < acc_q) ovf_d = 1'b1;
                    end
                end else begin
                    if (acc_q < opnd_q) begin
                        result_d = cnt_q;
                        rem_d    = acc_q;
                        state_d  = DONE;
                    end else begin
                        o_alu_sltr = SUBS;
                        o_alu_b    = opnd_q;
                        acc_d      = i_alu_val;
                        cnt_d      = cnt_q + ONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_ready  = (state_q == IDLE);
    assign o_done   = done_q;
    assign o_result = result_q;
    assign o_rem    = rem_q;
    assign o_ovf    = ovf_q;
    assign o_err    = err_q;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer that time-shares the single-cycle combinational alu (ops ADD, SUBS, NULL from pkg_system_mdr) to perform unsigned multiply by repeated addition and unsigned divide by repeated subtraction.
- Sits between the MDR command source and the alu: owns the alu operand and selector inputs, and holds the accumulator and iteration counter.
- Uses a start/ready request handshake and a one-cycle done pulse.

Parameters:
- DW, 8: operand, accumulator and counter width; must equal the width of data_t.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  command request; accepted only while o_ready=1.
- i_op  in  1  0=MUL, 1=DIV.
- i_a  in  DW  multiplicand / dividend; sampled on the accept edge.
- i_b  in  DW  multiplier / divisor; sampled on the accept edge.
- o_ready  out  1  high only in state IDLE.
- o_done  out  1  one-cycle pulse; result valid.
- o_result  out  DW  product (mod 2^DW) or quotient.
- o_rem  out  DW  remainder for DIV; 0 for MUL.
- o_ovf  out  1  MUL overflow occurred.
- o_err  out  1  divide by zero.
- o_alu_a  out  DW  alu operand A.
- o_alu_b  out  DW  alu operand B.
- o_alu_sltr  out  op_t  alu operation select.
- i_alu_val  in  DW  alu result.

Behaviour:
- Reset state:
  - State = IDLE; accumulator, counter, addend/divisor registers = 0.
  - o_done, o_result, o_rem, o_ovf, o_err = 0; o_ready = 1.
- Registered state and status: the FSM state, accumulator (acc), counter (cnt) and all status outputs are registered. The alu path is combinational from acc.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accept when i_start=1, on the rising edge.
  - Capture i_op, i_a and i_b.
  - Clear o_ovf and o_err. o_result and o_rem hold their previous values until DONE.
  - MUL: acc=0, cnt=0, addend=i_a, limit=i_b. Go to RUN.
  - DIV with i_b≠0: acc=i_a, cnt=0, divisor=i_b. Go to RUN.
  - DIV with i_b=0: o_err=1. Go straight to DONE with o_result=all ones and o_rem=i_a.
- RUN, MUL:
  - If cnt==limit: go to DONE, o_result=acc, o_rem=0.
  - Else: drive alu with a=acc, b=addend, sltr=ADD; acc←i_alu_val; cnt←cnt+1.
  - If i_alu_val < acc (unsigned wrap), set o_ovf=1. o_ovf is sticky for the rest of the command.
- RUN, DIV:
  - If acc < divisor: go to DONE, o_result=cnt, o_rem=acc.
  - Else: drive alu with sltr=SUBS, a=acc, b=divisor; acc←i_alu_val; cnt←cnt+1.
- Idle alu drive: whenever no operation is issued, o_alu_sltr=NULL, o_alu_a=acc, o_alu_b=0.
- DONE: o_done=1 for exactly one cycle, then go to IDLE. Results hold until the next DONE.
- Latency, measured from the accept edge to o_done high:
  - MUL: limit+2 cycles.
  - DIV: quotient+2 cycles.
  - DIV by zero: 1 cycle.
- i_start while busy: ignored, not queued.
- i_start in the DONE cycle: ignored. The next accept is possible in the following IDLE cycle.
- Reset mid-RUN or mid-DONE: immediate return to the reset state; no o_done pulse; the partial result is discarded.
- Width rules: all arithmetic is unsigned DW bits. cnt never exceeds 2^DW-1, because limit ≤ 2^DW-1 and quotient ≤ i_a.

Optional Feature:
- Macro: ALU_SEQ_MUL_SWAP_EN.
- Defined:
  - On MUL accept, limit=min(i_a,i_b) and addend=max(i_a,i_b).
  - MUL latency becomes min(i_a,i_b)+2. Result and overflow are unchanged.
- Undefined: limit=i_b and addend=i_a, exactly as in Behaviour.
- DIV behaviour is identical either way.

Test Plan:
- MUL i_a=7, i_b=5 → o_done 7 cycles after accept; o_result=35, o_rem=0, o_ovf=0. Check alu sltr=ADD for 5 cycles, NULL otherwise.
- MUL i_a=20, i_b=20 (DW=8) → o_result=144 (400 mod 256), o_ovf=1, o_done 22 cycles after accept.
- DIV i_a=100, i_b=7 → o_result=14, o_rem=2, o_done 16 cycles after accept. Boundary case DIV 5/9 → o_result=0, o_rem=5, latency 2.
- DIV i_a=42, i_b=0 → o_err=1, o_result=0xFF, o_rem=42, o_done 1 cycle after accept, no SUBS issued.
- MUL 3×200 with i_start re-pulsed mid-run, then rst asserted at cycle 50 → re-pulse ignored; all outputs at reset values asynchronously; o_ready=1; no o_done pulse.
- ALU_SEQ_MUL_SWAP_EN defined, MUL i_a=200, i_b=3 → o_result=88 (600 mod 256), o_ovf=1, latency 5. Undefined → identical result, latency 5. With i_a=3, i_b=200: defined → latency 5; undefined → latency 202.
